// File: rtl/spi_pkg.sv
// Shared types and sizing helpers for the spi_master_rx block and its clock generator.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } mode_t;

    // Index width that never collapses to zero bits (also gives CS_W).
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period timer: one-cycle tick every CLK_DIV cycles plus a count of ticks seen,
// held at zero while the master is idle.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int IDX_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    output logic             tick,
    output logic [IDX_W-1:0] toggle_idx
);

    localparam int DIV_W = clog2_min1(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    assign tick = !clr && (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            div_cnt    <= '0;
            toggle_idx <= '0;
        end else if (tick) begin
            div_cnt    <= '0;
            toggle_idx <= toggle_idx + IDX_W'(1);
        end else begin
            div_cnt    <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_master_rx.sv
// SPI master reading DATA_W-bit words from one of NUM_CS slaves, all four CPOL/CPHA modes.
// Define SPI_TX_EN to add the tx_data/mosi transmit path.
module spi_master_rx
    import spi_pkg::*;
#(
    parameter  int DATA_W  = 8,
    parameter  int CLK_DIV = 4,
    parameter  int NUM_CS  = 1,
    localparam int CS_W    = clog2_min1(NUM_CS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              miso,
`ifdef SPI_TX_EN
    input  logic [DATA_W-1:0] tx_data,
    output logic              mosi,
`endif
    output logic              sclk,
    output logic [NUM_CS-1:0] cs_n,
    output logic              busy,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid
);

    localparam int TOGGLES = 2 * DATA_W;
    localparam int IDX_W   = $clog2(TOGGLES + 3);
    localparam logic [IDX_W-1:0] TOG_END  = IDX_W'(TOGGLES);
    localparam logic [CS_W:0]    CS_LIMIT = (CS_W + 1)'(NUM_CS);

    state_t            state;
    mode_t             mode;
    logic [DATA_W-1:0] rx_sr;
    logic              tick;
    logic [IDX_W-1:0]  toggle_idx;
    logic              accept;
    logic              toggle;
    logic              sample;

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV),
        .IDX_W   (IDX_W)
    ) u_clk_gen (
        .clk        (clk),
        .rst        (rst),
        .clr        (state == IDLE),
        .tick       (tick),
        .toggle_idx (toggle_idx)
    );

    // Tick n (0-based) starts half-period n+1; ticks past the last toggle close XFER and HOLD.
    assign accept = (state == IDLE) && start && ({1'b0, cs_sel} < CS_LIMIT);
    assign toggle = tick && (toggle_idx < TOG_END);
    assign sample = toggle && (toggle_idx[0] == mode.cpha);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mode       <= '0;
            rx_sr      <= '0;
            sclk       <= 1'b0;
            cs_n       <= '1;
            busy       <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (sample) begin
                rx_sr <= {rx_sr[DATA_W-2:0], miso};
            end
            if (toggle) begin
                sclk <= ~sclk;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        mode.cpol <= cpol;
                        mode.cpha <= cpha;
                        sclk      <= cpol;
                        cs_n      <= ~(NUM_CS'(1) << cs_sel);
                        busy      <= 1'b1;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (tick) begin
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (tick && !toggle) begin
                        sclk  <= mode.cpol;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (tick) begin
                        cs_n       <= '1;
                        busy       <= 1'b0;
                        data_out   <= rx_sr;
                        data_valid <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPI_TX_EN
    logic [DATA_W-1:0] tx_sr;

    // With cpha=0 the MSB must already be on the line for the first (leading) sample edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_sr <= '0;
            mosi  <= 1'b0;
        end else if (accept) begin
            if (!cpha) begin
                mosi  <= tx_data[DATA_W-1];
                tx_sr <= {tx_data[DATA_W-2:0], 1'b0};
            end else begin
                mosi  <= 1'b0;
                tx_sr <= tx_data;
            end
        end else if (toggle && !sample) begin
            mosi  <= tx_sr[DATA_W-1];
            tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
        end else if ((state == HOLD) && tick) begin
            mosi  <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_spi_master_rx.sv
// Directed bench for spi_master_rx (DATA_W=8, CLK_DIV=4, NUM_CS=3) with a behavioural SPI slave.
// Define SPI_TX_EN to also exercise the mosi loopback path.
module tb_spi_master_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] cs_sel;
    logic       cpol;
    logic       cpha;
    logic       miso;
    logic       sclk;
    logic [2:0] cs_n;
    logic       busy;
    logic [7:0] data_out;
    logic       data_valid;
`ifdef SPI_TX_EN
    logic [7:0] tx_data;
    logic       mosi;
    logic       loop_en;
`endif

    logic [7:0] slave_word = 8'h00;
    logic       slave_cpha = 1'b0;
    logic       slave_miso = 1'b0;
    logic       sl_active  = 1'b0;
    logic       sl_prev    = 1'b0;
    int         sl_cnt     = 0;
    int         sl_idx     = 0;

    int   checks   = 0;
    int   failures = 0;
    int   c;
    int   toggles;
    int   low;
    logic prev;
    logic bad;
    logic done;
    logic seen;

    always #5 clk = ~clk;

`ifdef SPI_TX_EN
    assign miso = loop_en ? mosi : slave_miso;
`else
    assign miso = slave_miso;
`endif

    spi_master_rx #(
        .DATA_W  (8),
        .CLK_DIV (4),
        .NUM_CS  (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cs_sel     (cs_sel),
        .cpol       (cpol),
        .cpha       (cpha),
        .miso       (miso),
`ifdef SPI_TX_EN
        .tx_data    (tx_data),
        .mosi       (mosi),
`endif
        .sclk       (sclk),
        .cs_n       (cs_n),
        .busy       (busy),
        .data_out   (data_out),
        .data_valid (data_valid)
    );

    // Slave: MSB first; cpha=0 presents bit 0 at select and shifts on trailing edges,
    // cpha=1 shifts on leading edges. Updates at negedge, away from the master's sampling.
    always @(negedge clk) begin
        if (&cs_n) begin
            sl_active = 1'b0;
        end else if (!sl_active) begin
            sl_active = 1'b1;
            sl_cnt    = 0;
        end else if (sclk !== sl_prev) begin
            sl_cnt = sl_cnt + 1;
        end
        sl_prev = sclk;
        sl_idx  = slave_cpha ? ((sl_cnt == 0) ? 0 : (sl_cnt - 1) / 2) : sl_cnt / 2;
        if (sl_idx > 7) sl_idx = 7;
        slave_miso = slave_word[7 - sl_idx];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic p, input logic h, input logic [1:0] sel, input logic [7:0] word);
        cpol       = p;
        cpha       = h;
        cs_sel     = sel;
        slave_word = word;
        slave_cpha = h;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Called one cycle after the accepting edge k; returns in the data_valid cycle.
    task automatic wait_done(input logic [1:0] sel, input logic exp_idle, input logic [7:0] exp_data,
                             input logic poke);
        logic [2:0] exp_low;
        exp_low = ~(3'b001 << sel);
        check("busy_after_start", busy, 1);
        prev    = sclk;
        toggles = 0;
        low     = 0;
        bad     = 1'b0;
        done    = 1'b0;
        c       = 0;
        while (!done && c < 200) begin
            if (poke && c == 10) begin
                start  = 1'b1;
                cs_sel = 2'd1;
                cpol   = ~cpol;
                cpha   = ~cpha;
            end
            if (poke && c == 11) start = 1'b0;
            if (sclk !== prev) toggles++;
            prev = sclk;
            if (cs_n !== 3'b111 && cs_n !== exp_low) bad = 1'b1;
            if (cs_n === exp_low) low++;
            if (data_valid === 1'b1) begin
                done = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                c++;
            end
        end
        check("valid_seen", done, 1);
        check("latency", c + 1, 73);
        check("data_out", data_out, exp_data);
        check("sclk_toggles", toggles, 16);
        check("cs_low_cycles", low, 72);
        check("cs_only_selected", bad, 0);
        check("cs_released", cs_n, 3'b111);
        check("busy_at_valid", busy, 0);
        check("sclk_idle_after", sclk, exp_idle);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        cs_sel     = 2'd0;
        cpol       = 1'b0;
        cpha       = 1'b0;
`ifdef SPI_TX_EN
        tx_data    = 8'h00;
        loop_en    = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_sclk", sclk, 0);
        check("rst_cs_n", cs_n, 3'b111);
        check("rst_busy", busy, 0);
        check("rst_valid", data_valid, 0);
        check("rst_data", data_out, 8'h00);
`ifdef SPI_TX_EN
        check("rst_mosi", mosi, 0);
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Mode 0, slave 0
        launch(1'b0, 1'b0, 2'd0, 8'hA5);
        wait_done(2'd0, 1'b0, 8'hA5, 1'b0);
        @(posedge clk);
        #1;
        check("valid_one_cycle", data_valid, 0);
        check("data_holds", data_out, 8'hA5);

        // Mode 3: sclk idles high in SETUP and after
        launch(1'b1, 1'b1, 2'd0, 8'h3C);
        check("m3_sclk_setup", sclk, 1);
        wait_done(2'd0, 1'b1, 8'h3C, 1'b0);

        // Mode 1 on slave 2
        repeat (2) @(posedge clk);
        #1;
        launch(1'b0, 1'b1, 2'd2, 8'hC3);
        wait_done(2'd2, 1'b0, 8'hC3, 1'b0);

        // Out-of-range select is ignored
        repeat (2) @(posedge clk);
        #1;
        cs_sel = 2'd3;
        cpol   = 1'b1;
        start  = 1'b1;
        seen   = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b0 || cs_n !== 3'b111 || sclk !== 1'b0) seen = 1'b1;
        end
        start = 1'b0;
        check("bad_sel_ignored", seen, 0);

        // Mode 2 with start/inputs poked mid-transfer, then back-to-back start on data_valid
        launch(1'b1, 1'b0, 2'd0, 8'h96);
        wait_done(2'd0, 1'b1, 8'h96, 1'b1);
        check("gap_cs_high", cs_n, 3'b111);
        launch(1'b0, 1'b0, 2'd1, 8'h0F);
        check("chain_cs_low", cs_n, 3'b101);
        check("chain_busy", busy, 1);
        wait_done(2'd1, 1'b0, 8'h0F, 1'b0);

        // Reset on toggle 7 of a mode 2 transfer
        @(posedge clk);
        #1;
        launch(1'b1, 1'b0, 2'd1, 8'h77);
        prev    = sclk;
        toggles = 0;
        c       = 0;
        while (toggles < 7 && c < 100) begin
            @(posedge clk);
            #1;
            c++;
            if (sclk !== prev) toggles++;
            prev = sclk;
        end
        check("reach_toggle7", toggles, 7);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_cs_n", cs_n, 3'b111);
        check("midrst_sclk", sclk, 0);
        check("midrst_busy", busy, 0);
        check("midrst_data", data_out, 8'h00);
        check("midrst_valid", data_valid, 0);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (data_valid !== 1'b0 || busy !== 1'b0 || cs_n !== 3'b111) seen = 1'b1;
        end
        check("midrst_quiet", seen, 0);

`ifdef SPI_TX_EN
        // mosi looped to miso in all four modes
        loop_en = 1'b1;
        tx_data = 8'h5A;
        for (int m = 0; m < 4; m++) begin
            launch(m[1], m[0], 2'd0, 8'h00);
            wait_done(2'd0, m[1], 8'h5A, 1'b0);
            check("tx_mosi_idle", mosi, 0);
            @(posedge clk);
            #1;
        end
        loop_en = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_master_rx.md
Name: spi_master_rx

Overview:
Parametrised SPI master that reads DATA_W-bit words from one of NUM_CS slaves. It supersedes the fixed 8-bit, single-slave spi_driver in the reaction-timer top level. It adds a programmable SCLK divider, runtime selection of all four CPOL/CPHA modes, per-transfer chip-select choice and a start/busy/valid handshake. It sits between the top-level pins and the timer/score logic, which consumes data_out when data_valid is high.

Parameters:
DATA_W, 8, bits per transfer; must be >= 2.
CLK_DIV, 4, clk cycles per SCLK half-period; must be >= 1.
NUM_CS, 1, number of chip-select lines; must be >= 1.
CS_W, derived localparam, max(1, clog2(NUM_CS)); width of cs_sel.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst  in  1  reset, synchronous, active-high.
start  in  1  request a transfer; sampled only in IDLE.
cs_sel  in  CS_W  target slave index; latched on an accepted start.
cpol  in  1  SCLK idle level; latched on an accepted start.
cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; latched on an accepted start.
miso  in  1  serial data from the slave.
sclk  out  1  SPI clock.
cs_n  out  NUM_CS  active-low chip selects.
busy  out  1  high from the cycle after an accepted start until data_valid.
data_out  out  DATA_W  last received word; holds its value between transfers.
data_valid  out  1  one-cycle pulse when data_out updates.

Behaviour:
- Reset values: sclk=0, cs_n all 1, busy=0, data_valid=0, data_out=0, FSM=IDLE.
- Reset mid-transfer: the partial word is discarded and data_out is cleared. No data_valid is generated.
- FSM states: IDLE -> SETUP -> XFER -> HOLD -> IDLE.
- IDLE:
  - sclk = latched cpol (0 after reset); busy=0.
  - start=1 with cs_sel < NUM_CS: latch cs_sel/cpol/cpha and go to SETUP.
  - start=1 with cs_sel >= NUM_CS: ignored; no state change and no error flag.
- SETUP: cs_n[sel]=0; sclk idle; lasts CLK_DIV cycles.
- XFER:
  - 2*DATA_W half-periods of CLK_DIV cycles each. sclk toggles at the start of each half-period; toggles are numbered 1..2*DATA_W.
  - Sample edges: odd toggles when cpha=0, even toggles when cpha=1.
  - On the clk edge that produces a sample toggle, miso is shifted in MSB-first.
- HOLD: sclk at idle level, cs_n[sel] still 0; lasts CLK_DIV cycles.
- Completion, in the next cycle after HOLD: cs_n all 1, data_out = shift register, data_valid=1, busy=0, state IDLE.
- Latency: with start accepted at edge k, busy=1 from k+1 and data_valid at k+1+CLK_DIV*(2*DATA_W+2). For DATA_W=8, CLK_DIV=4 that is k+73.
- Inter-transfer gap: start is ignored while busy. A start asserted in the data_valid cycle is accepted, giving at least 1 cycle of cs_n high between transfers.
- Inputs cpol/cpha/cs_sel may change during a transfer without effect.
- Only one cs_n bit is ever low at a time.

Optional Feature:
Macro SPI_TX_EN.
- Defined: adds port tx_data (in, DATA_W) and mosi (out, 1).
  - tx_data is latched on an accepted start.
  - mosi is driven MSB-first and changes on the non-sample toggles.
  - With cpha=0, bit DATA_W-1 is valid from the first SETUP cycle.
  - mosi is 0 in IDLE and after reset.
- Undefined: no tx_data or mosi ports and no TX shift register; the block is receive-only.

Decomposition:
- Package spi_pkg:
  - state enum (IDLE, SETUP, XFER, HOLD);
  - mode struct {cpol, cpha};
  - constant function for CS_W.
- One sub-module, spi_clk_gen:
  - CLK_DIV counter emitting a one-cycle half-period tick and a toggle index;
  - cleared by rst and whenever the FSM is in IDLE.

Test Plan:
1. Mode 0, DATA_W=8, CLK_DIV=4, slave model returns 0xA5 -> data_out=0xA5; data_valid at k+73; cs_n[0] low for 72 cycles; 16 sclk toggles.
2. Mode 3 (cpol=1, cpha=1), slave returns 0x3C -> sclk idles 1 before and after; data_out=0x3C; sampling on rising edges.
3. NUM_CS=3, cs_sel=2 -> only cs_n[2] toggles low. cs_sel=3 -> start ignored, busy stays 0, no sclk activity.
4. start pulsed during busy -> ignored. start held in the data_valid cycle -> second transfer begins; cs_n high exactly 1 cycle between transfers.
5. rst=1 on toggle 7 -> next cycle cs_n=3'b111, sclk=0, busy=0, data_out=0, no data_valid.
6. SPI_TX_EN defined, mosi looped to miso, tx_data=0x5A, all four modes -> data_out=0x5A each time.
